// File: rtl/port_arbiter.sv
// port_arbiter: registered N-way arbiter.
//   Selection is either fixed priority or round robin. An optional lock holds
//   the current grant until the consumer acknowledges the transfer, or until
//   the granted request drops.
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   request_i       per-port request
//   acknowledge_i   per-port release, only the granted bit matters
//   grant_o         one-hot grant (registered)
//   grant_valid_o   grant is nonzero (registered)
//   grant_encoded_o index of the granted port (registered)
module port_arbiter #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0,
  localparam int CL = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request_i,
  input  logic [PORTS-1:0] acknowledge_i,
  output logic [PORTS-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [CL-1:0]    grant_encoded_o
);

  logic [PORTS-1:0] grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic [CL-1:0]    grant_encoded_q, grant_encoded_d;
  logic [PORTS-1:0] mask_q, mask_d;

  logic [PORTS-1:0] masked_req;
  logic             req_any, masked_any;
  logic [CL-1:0]    req_idx, masked_idx, sel_idx;

  assign masked_req = request_i & mask_q;
  assign req_any    = |request_i;
  assign masked_any = |masked_req;

  // Two priority encoders. The scan runs from lowest to highest priority so
  // the last hit, i.e. the highest-priority set bit, wins.
  always_comb begin
    req_idx    = '0;
    masked_idx = '0;
    if (ARB_LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (request_i[i])  req_idx    = CL'(i);
        if (masked_req[i]) masked_idx = CL'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (request_i[i])  req_idx    = CL'(i);
        if (masked_req[i]) masked_idx = CL'(i);
      end
    end
  end

  // Round robin prefers ports below the last winner; an empty masked set
  // wraps back to the plain priority winner.
  assign sel_idx = (ARB_TYPE_ROUND_ROBIN != 0 && masked_any) ? masked_idx : req_idx;

  always_comb begin
    grant_d         = '0;
    grant_valid_d   = 1'b0;
    grant_encoded_d = '0;
    mask_d          = mask_q;
    if (ARB_BLOCK != 0 && ARB_BLOCK_ACK == 0 && (grant_q & request_i) != '0) begin
      grant_d         = grant_q;
      grant_valid_d   = grant_valid_q;
      grant_encoded_d = grant_encoded_q;
    end else if (ARB_BLOCK != 0 && ARB_BLOCK_ACK != 0 && grant_valid_q &&
                 (grant_q & acknowledge_i) == '0) begin
      grant_d         = grant_q;
      grant_valid_d   = grant_valid_q;
      grant_encoded_d = grant_encoded_q;
    end else if (req_any) begin
      grant_d         = PORTS'(1) << sel_idx;
      grant_valid_d   = 1'b1;
      grant_encoded_d = sel_idx;
      if (ARB_TYPE_ROUND_ROBIN != 0) begin
        // Shift amounts are widened so idx+1 cannot wrap at CL bits.
        if (ARB_LSB_HIGH_PRIORITY != 0)
          mask_d = {PORTS{1'b1}} << (int'(sel_idx) + 1);
        else
          mask_d = {PORTS{1'b1}} >> (PORTS - int'(sel_idx));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q         <= '0;
      grant_valid_q   <= 1'b0;
      grant_encoded_q <= '0;
      mask_q          <= '0;
    end else begin
      grant_q         <= grant_d;
      grant_valid_q   <= grant_valid_d;
      grant_encoded_q <= grant_encoded_d;
      mask_q          <= mask_d;
    end
  end

  assign grant_o         = grant_q;
  assign grant_valid_o   = grant_valid_q;
  assign grant_encoded_o = grant_encoded_q;

endmodule

// File: tb/tb_port_arbiter.sv
module tb_port_arbiter;

  localparam int NCFG = 8;
  localparam int NRAND = 3000;
  // Per-instance configuration: ports, round robin, block, block-on-ack, lsb-high.
  localparam int C_P   [NCFG] = '{4, 4, 4, 4, 4, 4, 1, 3};
  localparam int C_RR  [NCFG] = '{0, 0, 1, 1, 0, 1, 1, 1};
  localparam int C_BLK [NCFG] = '{0, 0, 0, 1, 1, 1, 1, 0};
  localparam int C_ACK [NCFG] = '{1, 1, 1, 1, 0, 0, 1, 1};
  localparam int C_LSB [NCFG] = '{1, 0, 1, 1, 1, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_s = 1'b1;
  logic [3:0] req_s = '0;
  logic [3:0] ack_s = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  typedef struct {
    int g;
    int v;
    int e;
  } exp_t;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int P   = C_P[g];
    localparam int CLW = (P > 1) ? $clog2(P) : 1;

    logic [P-1:0]   grant;
    logic           grant_valid;
    logic [CLW-1:0] grant_enc;

    port_arbiter #(
      .PORTS(P),
      .ARB_TYPE_ROUND_ROBIN(C_RR[g]),
      .ARB_BLOCK(C_BLK[g]),
      .ARB_BLOCK_ACK(C_ACK[g]),
      .ARB_LSB_HIGH_PRIORITY(C_LSB[g])
    ) dut (
      .clk(clk),
      .rst(rst_s),
      .request_i(req_s[P-1:0]),
      .acknowledge_i(ack_s[P-1:0]),
      .grant_o(grant),
      .grant_valid_o(grant_valid),
      .grant_encoded_o(grant_enc)
    );

    exp_t sb[$];

    // Reference model state: current holder and the last round-robin winner.
    int  m_valid = 0;
    int  m_idx = 0;
    int  m_has_last = 0;
    int  m_last = 0;

    // 0 is the most important port in this configuration.
    function automatic int rank(int i);
      return (C_LSB[g] != 0) ? i : (P - 1 - i);
    endfunction

    function automatic int pick(logic [3:0] req, int use_after, int after_rank);
      int best = -1;
      for (int i = 0; i < P; i++) begin
        if (req[i] && (use_after == 0 || rank(i) > after_rank)) begin
          if (best < 0 || rank(i) < rank(best)) best = i;
        end
      end
      return best;
    endfunction

    initial begin
      forever begin
        exp_t x;
        logic [3:0] rq;
        int w;
        @(negedge clk);
        #1;
        rq = req_s & 4'((1 << P) - 1);
        if (rst_s) begin
          m_valid = 0; m_idx = 0; m_has_last = 0; m_last = 0;
        end else if (C_BLK[g] != 0 && C_ACK[g] == 0 && m_valid != 0 && rq[m_idx]) begin
          // locked until the holder drops its request
        end else if (C_BLK[g] != 0 && C_ACK[g] != 0 && m_valid != 0 && !ack_s[m_idx]) begin
          // locked until the holder is acknowledged
        end else if (rq != 4'b0) begin
          w = -1;
          if (C_RR[g] != 0 && m_has_last != 0) w = pick(rq, 1, rank(m_last));
          if (w < 0) w = pick(rq, 0, 0);
          m_valid = 1;
          m_idx = w;
          if (C_RR[g] != 0) begin
            m_has_last = 1;
            m_last = w;
          end
        end else begin
          m_valid = 0;
          m_idx = 0;
        end
        x.v = m_valid;
        x.e = (m_valid != 0) ? m_idx : 0;
        x.g = (m_valid != 0) ? (1 << m_idx) : 0;
        sb.push_back(x);
      end
    end

    initial begin
      @(negedge clk);
      forever begin
        exp_t x;
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL cfg%0d scoreboard_empty: no expected entry queued at %0t", g, $time);
        end else begin
          x = sb.pop_front();
          if (int'(grant) != x.g) begin
            n_fail++;
            $display("FAIL cfg%0d grant: got %0h expected %0h at %0t", g, grant, x.g, $time);
          end
          n_checks++;
          if (int'(grant_valid) != x.v) begin
            n_fail++;
            $display("FAIL cfg%0d grant_valid: got %0d expected %0d at %0t", g, grant_valid, x.v, $time);
          end
          n_checks++;
          if (int'(grant_enc) != x.e) begin
            n_fail++;
            $display("FAIL cfg%0d grant_encoded: got %0d expected %0d at %0t", g, grant_enc, x.e, $time);
          end
        end
      end
    end
  end

  // Directed scenarios first, packed as {rst, ack[3:0], req[3:0]}.
  localparam int NDIR = 33;
  localparam logic [8:0] DIR [NDIR] = '{
    9'h100, 9'h100,
    9'h00A, 9'h000,
    9'h00F, 9'h00F, 9'h00F, 9'h00F, 9'h00F,
    9'h000,
    9'h003, 9'h003, 9'h003, 9'h003,
    9'h043, 9'h003, 9'h013, 9'h003, 9'h003, 9'h023, 9'h000,
    9'h004, 9'h004, 9'h005, 9'h005, 9'h001, 9'h000,
    9'h004, 9'h004,
    9'h104, 9'h00F, 9'h00F, 9'h000
  };

  initial begin
    logic [8:0] v;
    rst_s = 1'b1;
    req_s = '0;
    ack_s = '0;
    for (int i = 0; i < NDIR; i++) begin
      @(negedge clk);
      v = DIR[i];
      rst_s = v[8];
      ack_s = v[7:4];
      req_s = v[3:0];
    end
    for (int i = 0; i < NRAND; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req_s = 4'($urandom_range(0, 15));
      ack_s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      rst_s = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst_s = 1'b0;
    req_s = '0;
    ack_s = '0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
Name: port_arbiter

Overview:
- Registered N-way arbiter with a one-hot grant, a valid flag and a binary-encoded index.
- Supports fixed-priority or round-robin selection, with optional grant locking.
- Used by request/descriptor muxes to pick one input port at a time; with ARB_BLOCK_ACK the grant is held until the consumer acknowledges the transfer.

Parameters:
- PORTS, 4, number of requesters (>=1).
- ARB_TYPE_ROUND_ROBIN, 0, 1 = round-robin; 0 = fixed priority.
- ARB_BLOCK, 0, 1 = hold the current grant until released (see ARB_BLOCK_ACK).
- ARB_BLOCK_ACK, 1, only used when ARB_BLOCK=1. 1 = release on acknowledge; 0 = release when the granted request drops.
- ARB_LSB_HIGH_PRIORITY, 0, 1 = bit 0 has highest priority; 0 = bit PORTS-1 has highest priority.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- request  in  PORTS  per-port request.
- acknowledge  in  PORTS  per-port release; only the granted bit is meaningful.
- grant  out  PORTS  one-hot grant, registered.
- grant_valid  out  1  grant is nonzero, registered.
- grant_encoded  out  CL  index of the granted port, registered. CL = max(1, clog2(PORTS)).

Behaviour:
- Registers: grant_reg, grant_valid_reg, grant_encoded_reg, mask_reg. Reset values are all 0.
- rst has priority over all next-state logic.
- Outputs come directly from the registers. Request-to-grant latency is one clock.
- Next-state defaults each cycle: grant=0, valid=0, encoded=0, mask=mask_reg. The first matching case below overrides them:
  1. ARB_BLOCK=1, ARB_BLOCK_ACK=0, and (grant_reg & request)!=0: hold grant, valid and encoded.
  2. ARB_BLOCK=1, ARB_BLOCK_ACK=1, grant_valid_reg=1, and (grant_reg & acknowledge)==0: hold.
  3. Any request bit set: select a new winner.
     - Fixed priority: the highest-priority set bit of request.
     - Round robin with (request & mask_reg)!=0: the highest-priority set bit of (request & mask_reg).
     - Round robin otherwise: the highest-priority set bit of request.
     - Set grant = 1<<idx, valid = 1, encoded = idx.
     - Round robin also updates the mask. LSB-high: mask = all-ones << (idx+1), i.e. ports above idx. MSB-high: mask = all-ones >> (PORTS-idx), i.e. ports below idx.
  4. Otherwise grant goes to 0 the next cycle.
- Blocking behaviour:
  - With ARB_BLOCK=0 the winner is re-evaluated every cycle; round robin still rotates, so a persistent single requester keeps its grant.
  - Acknowledge with grant_valid_reg=0 is ignored.
  - Acknowledge and a new request in the same cycle: release and re-arbitration happen together, so the new grant appears on the next edge with no idle cycle.
  - Acknowledge on a non-granted bit has no effect.
- Round-robin fairness: after port idx wins, every other requesting port at lower priority wins before idx again. When the mask is empty or masks every request, the scheme wraps to the unmasked winner.
- Reset mid-grant: grant, valid, encoded and mask clear on the next edge. Arbitration restarts from the highest-priority port.
- PORTS=1: grant mirrors the single request per the rules above; encoded is always 0.
- Implementation is purely synchronous with no combinational path from inputs to outputs. It contains two priority encoders (full request and masked request).

Test Plan:
- PORTS=4, fixed priority, LSB-high, no block. request=4'b1010 -> next cycle grant=4'b0010, encoded=1, valid=1. Then request=0 -> grant=0, valid=0.
- Same configuration with ARB_LSB_HIGH_PRIORITY=0. request=4'b1010 -> grant=4'b1000, encoded=3.
- Round robin, LSB-high, no block. request=4'b1111 held -> encoded sequence 0,1,2,3,0 on consecutive cycles.
- Round robin, ARB_BLOCK=1, ARB_BLOCK_ACK=1. request=4'b0011 -> grant=4'b0001 and held for 3 cycles with acknowledge=0. Pulse acknowledge=4'b0001 -> next cycle grant=4'b0010. An acknowledge=4'b0100 pulse does not release.
- ARB_BLOCK=1, ARB_BLOCK_ACK=0, fixed LSB-high. Port 2 granted; raise port 0 while port 2 stays high -> grant stays 4'b0100. Drop port 2 -> next cycle grant=4'b0001.
- Assert rst while grant=4'b0100 and valid=1 -> next cycle grant=0, valid=0, encoded=0. After release with request=4'b1111 under round robin -> grant=4'b0001.
